seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-cathode 7-segment digits that share one 4-to-7 BCD segment decoder.
- Holds a packed multi-digit BCD value, sequences one digit at a time onto the shared decoder input, and drives the matching digit-enable line.
- Inserts a dark guard interval between digits to prevent ghosting.
- Applies new values only at frame boundaries (no tearing) and optionally suppresses leading zeros.
- Sits between the datapath that produces the display value and the segment decoder/pin drivers.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 2..8.
- DIV, 1000, clock cycles each digit is lit; must be >= 1.
- GUARD, 16, dark cycles after each digit; 0 = no guard phase.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  scan enable; low = freeze and go dark.
- load  input  1  single-cycle strobe; captures data_in.
- data_in  input  4*DIGITS  packed BCD; nibble k = digit k, digit 0 least significant.
- lz_en  input  1  leading-zero suppression enable.
- dec_in  output  4  nibble to shared decoder; 4'hF = blank (decoder drives all segments off for codes > 9).
- dig_sel  output  DIGITS  one-hot, active-high digit enable.
- frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled high at a rising clk edge resets all state.
- Reset values: pending register = 0, pending flag = 0, display register = 0, idx = 0, state = SHOW, cnt = 0, dig_sel = 0, dec_in = 4'hF, frame_done = 0.
- rst takes priority over load and en. Reset mid-frame aborts the frame and discards any pending load.
- Load path:
  - load = 1 at an edge: pending <= data_in and pending flag set. Accepted in any state and regardless of en.
  - Repeated loads before commit: the last one wins.
- Commit: at the frame wrap edge, display <= pending if the pending flag is set, and the flag clears. The display register never changes mid-frame.
- FSM:
  - SHOW: cnt counts 0..DIV-1. At DIV-1, go to GUARD with cnt = 0, or, if GUARD = 0, advance idx directly.
  - GUARD: cnt counts 0..GUARD-1. At GUARD-1, advance idx and return to SHOW with cnt = 0.
  - Advance: idx <= idx+1. From DIGITS-1 it wraps to 0; this is the frame wrap, where the commit occurs and frame_done pulses.
- Frame length is DIGITS*(DIV+GUARD) cycles.
- Outputs are registered, one cycle after the state they reflect:
  - state SHOW: dig_sel = 1<<idx; dec_in = display nibble idx, or 4'hF if that digit is blanked.
  - state GUARD, or en = 0: dig_sel = 0, dec_in = 4'hF.
- frame_done is registered and asserts for exactly one cycle, in the cycle after the wrap edge.
- en = 0: idx, cnt and state hold and outputs go dark. When en returns to 1, the scan resumes from the held state with no restart.
- Leading-zero suppression, with lz_en = 1: digit k (k >= 1) is blanked iff nibbles DIGITS-1 down to k are all 0. Digit 0 is never blanked, so value 0 displays a single "0". With lz_en = 0, no digit is blanked.
- lz_en is sampled combinationally each cycle; no commit is needed.
- Non-BCD nibbles (A..F) pass through unchanged; the decoder renders them dark.
- No internal overflow is possible: cnt width is clog2(max(DIV,GUARD)), and idx width is clog2(DIGITS).

Test Plan (DIGITS=4, DIV=4, GUARD=1, frame = 20 cycles):
1. Release rst, en = 1, lz_en = 0, load 16'h1234 at cycle 3.
   - Frame 0: dec_in = 0 on every digit.
   - frame_done is high at cycle 20.
   - From the next cycle: dig_sel = 0001 with dec_in = 4 for 4 cycles, then 1 dark cycle (dig_sel = 0, dec_in = F), then 0010 with dec_in = 3, 0100 with 2, 1000 with 1.
2. lz_en = 1, display = 16'h0050 → digit3 F, digit2 F, digit1 5, digit0 0. Display = 16'h0000 → only digit0 lit, showing 0. Display = 16'h1000 → no blanking.
3. Load 16'h1111, then 16'h2222 two cycles later, both mid-frame → the current frame is unchanged; the next frame shows only 2222.
4. Drop en for 7 cycles mid-SHOW of digit 2 → dig_sel = 0 and dec_in = F for those cycles. When en returns, digit 2 completes its remaining SHOW cycles and frame_done is delayed by exactly 7 cycles.
5. Assert rst mid-GUARD with a load pending → the next cycle has dig_sel = 0, dec_in = F, frame_done = 0. After release, the scan restarts at digit 0 showing 0 and the pending value is never displayed.
6. Load 16'hA9F0 with lz_en = 1 → dec_in sequence 0, F, 9, A; nothing blanked because the top nibble is nonzero.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------------------------
// seg_scan_ctrl
//
// Scan controller for a bank of common-cathode 7-segment digits that share one BCD segment
// decoder. Each digit is lit for DIV cycles and then held dark for GUARD cycles so the decoder
// output can settle before the next digit is enabled. New display values are buffered and only
// take effect at a frame boundary, so a frame never shows a mix of old and new digits.
//
// Parameters:
//   DIGITS - number of digits scanned (2..8)
//   DIV    - cycles each digit is lit (>= 1)
//   GUARD  - dark cycles after each digit (0 removes the guard phase)
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   en         - scan enable; low freezes the scan position and blanks the outputs
//   load       - single-cycle strobe capturing data_in into the pending buffer
//   data_in    - packed BCD value, nibble k drives digit k (digit 0 least significant)
//   lz_en      - leading-zero suppression enable
//   dec_in     - nibble for the shared decoder; 4'hF means blank
//   dig_sel    - one-hot active-high digit enable
//   frame_done - one-cycle pulse in the cycle after each frame wrap
// ---------------------------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 1000,
    parameter int unsigned GUARD  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  lz_en,
    output logic [3:0]            dec_in,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    // One counter serves both phases, so it is sized for the longer of the two.
    localparam int unsigned CntMax    = (DIV > GUARD) ? DIV : GUARD;
    localparam int unsigned CntW      = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned IdxW      = $clog2(DIGITS);
    localparam logic [CntW-1:0] DivLast   = CntW'(DIV - 1);
    localparam logic [CntW-1:0] GuardLast = (GUARD > 0) ? CntW'(GUARD - 1) : '0;
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

    typedef enum logic [0:0] {
        StShow,
        StGuard
    } state_e;

    // State
    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;

    // Registered outputs
    logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
    logic [3:0]            dec_in_q, dec_in_d;
    logic                  frame_done_q, frame_done_d;

    // Combinational helpers
    logic                  advance;
    logic                  wrap;
    logic [3:0]            nib [DIGITS];
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     cur_onehot;
    logic [3:0]            cur_nib;
    logic                  cur_blank;

    // ------------------------------------------------------------------------------------------
    // Display digit decode and leading-zero blanking
    // ------------------------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < int'(DIGITS); k++) begin
            nib[k] = disp_q[4*k +: 4];
        end
    end

    // Walk from the most significant digit down; a digit is blank while every digit at or
    // above it is zero. Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        logic zero_above;
        zero_above = lz_en;
        blank      = '0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_above = zero_above & (nib[k] == 4'h0);
            blank[k]   = zero_above;
        end
    end

    always_comb begin
        cur_onehot = '0;
        cur_nib    = 4'h0;
        cur_blank  = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_onehot[k] = 1'b1;
                cur_nib       = nib[k];
                cur_blank     = blank[k];
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        advance = 1'b0;
        wrap    = 1'b0;

        if (en) begin
            case (state_q)
                StShow: begin
                    if (cnt_q == DivLast) begin
                        cnt_d = '0;
                        if (GUARD == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = StGuard;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StGuard: begin
                    if (cnt_q == GuardLast) begin
                        cnt_d   = '0;
                        state_d = StShow;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            endcase
        end

        if (advance) begin
            if (idx_q == IdxLast) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Pending buffer and frame-boundary commit
    // ------------------------------------------------------------------------------------------
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;

        // Commit uses the value pending before this edge; a load landing on the wrap edge
        // stays pending for the following frame.
        if (wrap && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end

        if (load) begin
            pend_d     = data_in;
            pend_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Output stage: reflects the state held before the current edge
    // ------------------------------------------------------------------------------------------
    always_comb begin
        dig_sel_d    = '0;
        dec_in_d     = 4'hF;
        frame_done_d = wrap;

        if (en && (state_q == StShow)) begin
            dig_sel_d = cur_onehot;
            dec_in_d  = cur_blank ? 4'hF : cur_nib;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StShow;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            disp_q       <= '0;
            dig_sel_q    <= '0;
            dec_in_q     <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            disp_q       <= disp_d;
            dig_sel_q    <= dig_sel_d;
            dec_in_q     <= dec_in_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dig_sel    = dig_sel_q;
    assign dec_in     = dec_in_q;
    assign frame_done = frame_done_q;

    // At most one digit may ever be driven, and a frame is always longer than one cycle.
    a_dig_sel_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(dig_sel_q));
    a_frame_done_pulse : assert property (@(posedge clk) disable iff (rst)
                                          frame_done_q |=> !frame_done_q);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=4, GUARD=1 (20-cycle frame). Each frame
// is run edge by edge against a hand-written vector of expected decoder codes, one nibble per
// digit, with optional loads, an enable gap or a reset injected at chosen edges.
// ---------------------------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;
    localparam int unsigned GUARD  = 1;
    localparam int          SLOT   = DIV + GUARD;
    localparam int          FRAME  = DIGITS * SLOT;

    logic                clk;
    logic                rst;
    logic                en;
    logic                load;
    logic [4*DIGITS-1:0] data_in;
    logic                lz_en;
    logic [3:0]          dec_in;
    logic [DIGITS-1:0]   dig_sel;
    logic                frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    seg_scan_ctrl #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .GUARD  (GUARD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .lz_en      (lz_en),
        .dec_in     (dec_in),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one frame from digit 0. codes holds the expected dec_in for each digit (nibble k =
    // digit k). la/lb: edge index of a load of va/vb (-1 = none). en is held low for off_len
    // edges starting at off_at. rst_at: edge index at which reset is applied, ending the frame.
    task automatic run_frame(input string tag, input logic [15:0] codes,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input int off_at, input int off_len, input int rst_at);
        int pos;
        int d;
        int p;
        pos = 0;
        for (int n = 0; n < FRAME + off_len; n++) begin
            if (n == la) begin
                load    = 1'b1;
                data_in = va;
            end else if (n == lb) begin
                load    = 1'b1;
                data_in = vb;
            end
            en = !(n >= off_at && n < off_at + off_len);

            if (n == rst_at) begin
                rst = 1'b1;
                step();
                rst  = 1'b0;
                load = 1'b0;
                check($sformatf("%s_rst_sel", tag), 32'(dig_sel), 32'h0);
                check($sformatf("%s_rst_dec", tag), 32'(dec_in), 32'hF);
                check($sformatf("%s_rst_fd", tag), 32'(frame_done), 32'h0);
                return;
            end

            step();
            load = 1'b0;

            if (!en) begin
                check($sformatf("%s_%0d_off_sel", tag, n), 32'(dig_sel), 32'h0);
                check($sformatf("%s_%0d_off_dec", tag, n), 32'(dec_in), 32'hF);
                check($sformatf("%s_%0d_off_fd", tag, n), 32'(frame_done), 32'h0);
            end else begin
                d = pos / SLOT;
                p = pos % SLOT;
                if (p < int'(DIV)) begin
                    check($sformatf("%s_%0d_sel", tag, n), 32'(dig_sel), 32'(1) << d);
                    check($sformatf("%s_%0d_dec", tag, n), 32'(dec_in), 32'(codes[4*d +: 4]));
                end else begin
                    check($sformatf("%s_%0d_gsel", tag, n), 32'(dig_sel), 32'h0);
                    check($sformatf("%s_%0d_gdec", tag, n), 32'(dec_in), 32'hF);
                end
                check($sformatf("%s_%0d_fd", tag, n), 32'(frame_done),
                      (pos == FRAME - 1) ? 32'h1 : 32'h0);
                pos++;
            end
        end
        en = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        load    = 1'b0;
        data_in = '0;
        lz_en   = 1'b0;
        step();
        step();
        check("reset_sel", 32'(dig_sel), 32'h0);
        check("reset_dec", 32'(dec_in), 32'hF);
        check("reset_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;

        // Power-up frame shows zeros; 1234 loaded mid-frame appears next frame.
        run_frame("f0", 16'h0000, 3, 16'h1234, -1, 16'h0, -1, 0, -1);
        run_frame("f1", 16'h1234, 10, 16'h0050, -1, 16'h0, -1, 0, -1);

        // Leading-zero suppression.
        lz_en = 1'b1;
        run_frame("f2", 16'hFF50, 0, 16'h0000, -1, 16'h0, -1, 0, -1);
        run_frame("f3", 16'hFFF0, 18, 16'h1000, -1, 16'h0, -1, 0, -1);

        // Two mid-frame loads: current frame untouched, last load wins.
        run_frame("f4", 16'h1000, 5, 16'h1111, 7, 16'h2222, -1, 0, -1);
        run_frame("f5", 16'h2222, 2, 16'hA9F0, -1, 16'h0, -1, 0, -1);

        // Non-BCD nibbles pass through; nonzero top nibble disables blanking.
        run_frame("f6", 16'hA9F0, -1, 16'h0, -1, 16'h0, -1, 0, -1);

        // Enable gap of 7 cycles during digit 2 SHOW stretches the frame by 7.
        run_frame("f7", 16'hA9F0, -1, 16'h0, -1, 16'h0, 12, 7, -1);

        // Reset during digit 1 GUARD with a load pending; pending value is discarded.
        run_frame("f8", 16'hA9F0, 2, 16'h5555, -1, 16'h0, -1, 0, 9);
        run_frame("f9", 16'hFFF0, -1, 16'h0, -1, 16'h0, -1, 0, -1);
        run_frame("f10", 16'hFFF0, -1, 16'h0, -1, 16'h0, -1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
